instr_queue: RTL and testbench
==============================

# instr_queue

Parametrised instruction buffer: the multi-entry successor to the single-entry instruction register between instruction memory and the control/decode logic. It holds up to DEPTH fetched instruction words, each with its fetch PC, in a FIFO with valid/ready handshakes on both sides and a synchronous flush for redirects. It decodes the head entry into the MIPS instruction fields plus a sign-extended immediate.

## Interface
- DEPTH, 4: number of entries; a power of two, at least 2.
- PC_W, 32: width of the stored fetch PC.
- CNT_W, $clog2(DEPTH+1): width of the occupancy count (derived; not overridden).

- clk  in  1  clock, all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush  in  1  synchronous discard of all entries.
- in_valid  in  1  fetch side offers in_instr/in_pc.
- in_ready  out  1  queue accepts; equals (count != DEPTH).
- in_instr  in  32  instruction word.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  head entry present; equals (count != 0).
- out_ready  in  1  decode consumes the head.
- out_pc  out  PC_W  PC of the head entry.
- opcode  out  6  head[31:26].
- rs  out  5  head[25:21].
- rt  out  5  head[20:16].
- rd  out  5  head[15:11].
- im  out  16  head[15:0].
- imm_sext  out  32  {{16{head[15]}}, head[15:0]}.
- funct  out  6  head[5:0].
- jump_address  out  26  head[25:0].
- count  out  CNT_W  current occupancy, 0..DEPTH.

## Operation
- Storage is DEPTH × (32 + PC_W) registers, with a write pointer, a read pointer (each log2(DEPTH) bits, wrapping modulo DEPTH) and a registered count.
- Push is in_valid && in_ready: the entry is written at wr_ptr, then wr_ptr increments.
- Pop is out_valid && out_ready: rd_ptr increments.
- count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged, both pointers advance.
- in_ready depends only on count. It does not depend on out_ready, so a full queue does not accept a word in the same cycle it pops.
- Flush has the highest priority:
  - wr_ptr, rd_ptr and count go to 0 at the edge.
  - A push or pop presented in the same cycle is discarded and has no effect.
  - Storage contents are not cleared.
- Decoded outputs and out_pc are combinational from the head slot (storage[rd_ptr]).
  - When out_valid=0, all of them are forced to 0.
  - Stale data is never visible.
- Reset (asynchronous, any time, including mid-push or mid-pop):
  - Pointers, count and all storage go to 0 immediately.
  - Therefore in_ready=1, out_valid=0, count=0, and every field output is 0.
- Operation resumes on the first rising edge after reset is deasserted.

## Timing
- Latency from a push to the word being visible at the head (queue empty beforehand): 1 cycle. There is no combinational bypass from in_instr to the outputs.
- Pop to next head: the new head appears right after the popping edge, so back-to-back pops sustain 1 instruction/cycle.
- Sustained throughput is 1 instruction/cycle with simultaneous push and pop whenever 0 < count < DEPTH.
- Full (count=DEPTH): in_ready=0. in_instr must be held by the producer until in_ready returns; this happens one edge after a pop.
- Empty (count=0): out_valid=0. out_ready is ignored.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no bubble.
- A flush asserted for several consecutive cycles keeps the queue empty. Pushing resumes on the first edge with flush=0.

## Test plan
- **Reset defaults.** Assert reset mid-cycle while count=2 → immediately count=0, out_valid=0, in_ready=1, opcode=0, imm_sext=0.
- **Single-entry decode.**
  - Stimulus: push 0x8C22FFFC at pc 0x100 into an empty queue.
  - Next cycle: out_valid=1, opcode=0x23, rs=1, rt=2, im=0xFFFC, imm_sext=0xFFFFFFFC, out_pc=0x100.
- **Fill to full (DEPTH=4).**
  - Stimulus: push 4 words with out_ready=0.
  - Required: count=4, in_ready=0. A fifth in_valid is not accepted and count stays 4.
  - Pop once → in_ready=1 on the next cycle.
- **Streaming and wrap-around.**
  - Stimulus: push 10 words 0x0000000A..0x00000013 with out_ready=1 every cycle.
  - Required: the output order equals the input order, count stays at 1 in steady state, and no word is lost or duplicated across pointer wrap.
- **Flush with simultaneous push and pop.**
  - Stimulus: at count=3, assert flush, in_valid and out_ready in the same cycle.
  - Required: the next cycle has count=0 and out_valid=0. The pushed word never appears at the output.
- **Simultaneous push and pop at count=1.** count stays 1, the head becomes the newly pushed word, and out_pc tracks that word's PC.

Source files
------------

// File: rtl/instr_queue.sv
// instr_queue: DEPTH-entry instruction/PC FIFO with valid/ready handshakes, flush and head-field decode
module instr_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W = 32,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [PC_W-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PC_W-1:0]  out_pc,
   output logic [5:0]       opcode,
   output logic [4:0]       rs,
   output logic [4:0]       rt,
   output logic [4:0]       rd,
   output logic [15:0]      im,
   output logic [31:0]      imm_sext,
   output logic [5:0]       funct,
   output logic [25:0]      jump_address,
   output logic [CNT_W-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   logic [31:0]      instr_q [DEPTH];
   logic [PC_W-1:0]  pc_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             push, pop;
   logic [31:0]      head;
   assign in_ready  = cnt_q != CNT_W'(DEPTH);
   assign out_valid = cnt_q != '0;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   always_comb begin
      wr_d  = flush ? '0 : wr_q + AW'(push);
      rd_d  = flush ? '0 : rd_q + AW'(pop);
      cnt_d = flush ? '0 : cnt_q + CNT_W'(push) - CNT_W'(pop);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_q[i] <= '0;
            pc_q[i]    <= '0;
         end
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
         if (push && !flush) begin
            instr_q[wr_q] <= in_instr;
            pc_q[wr_q]    <= in_pc;
         end
      end
   end
   // Gate the head with out_valid so slots left behind by pops or flushes never leak out
   assign head         = out_valid ? instr_q[rd_q] : '0;
   assign out_pc       = out_valid ? pc_q[rd_q] : '0;
   assign opcode       = head[31:26];
   assign rs           = head[25:21];
   assign rt           = head[20:16];
   assign rd           = head[15:11];
   assign im           = head[15:0];
   assign imm_sext     = {{16{head[15]}}, head[15:0]};
   assign funct        = head[5:0];
   assign jump_address = head[25:0];
   assign count        = cnt_q;
endmodule

// File: tb/tb_instr_queue.sv
// tb_instr_queue: directed and random checks of instr_queue against a queue-based reference model
module tb_instr_queue;
   localparam int DEPTH = 4;
   localparam int PC_W = 32;
   logic        clk = 0, reset = 1, flush = 0, in_valid = 0, out_ready = 0;
   logic        in_ready, out_valid;
   logic [31:0] in_instr = 0, in_pc = 0, out_pc, imm_sext;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd;
   logic [15:0] im;
   logic [25:0] jump_address;
   logic [2:0]  count;
   int          n_cmp = 0, n_err = 0;
   logic [31:0] m_instr[$], m_pc[$], popped[$];

   instr_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .im(im),
      .imm_sext(imm_sext), .funct(funct), .jump_address(jump_address), .count(count));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [31:0] h, p;
      int n;
      n = m_instr.size();
      h = n > 0 ? m_instr[0] : 32'd0;
      p = n > 0 ? m_pc[0] : 32'd0;
      chk({tag, ".count"}, 64'(count), 64'(n));
      chk({tag, ".out_valid"}, 64'(out_valid), 64'(n != 0));
      chk({tag, ".in_ready"}, 64'(in_ready), 64'(n != DEPTH));
      chk({tag, ".out_pc"}, 64'(out_pc), 64'(p));
      chk({tag, ".opcode"}, 64'(opcode), 64'(h / 32'h0400_0000));
      chk({tag, ".rs"}, 64'(rs), 64'((h >> 21) & 32'h1F));
      chk({tag, ".rt"}, 64'(rt), 64'((h >> 16) & 32'h1F));
      chk({tag, ".rd"}, 64'(rd), 64'((h >> 11) & 32'h1F));
      chk({tag, ".im"}, 64'(im), 64'(h % 32'h1_0000));
      chk({tag, ".imm_sext"}, 64'(imm_sext),
          64'((h & 32'h8000) != 0 ? (h | 32'hFFFF_0000) : (h & 32'h0000_FFFF)));
      chk({tag, ".funct"}, 64'(funct), 64'(h % 32'd64));
      chk({tag, ".jump"}, 64'(jump_address), 64'(h % 32'h0400_0000));
   endtask

   // Apply the current inputs to the model at the next edge, then let outputs settle
   task automatic cycle();
      bit do_push, do_pop;
      do_push = in_valid && m_instr.size() != DEPTH;
      do_pop  = out_ready && m_instr.size() != 0;
      if (!flush && do_pop) begin
         popped.push_back(m_instr[0]);
         void'(m_instr.pop_front());
         void'(m_pc.pop_front());
      end
      if (flush) begin
         m_instr.delete();
         m_pc.delete();
      end else if (do_push) begin
         m_instr.push_back(in_instr);
         m_pc.push_back(in_pc);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic r, input logic f, input logic [31:0] w, input logic [31:0] p);
      in_valid = v; out_ready = r; flush = f; in_instr = w; in_pc = p;
   endtask

   initial begin
      #12;
      check_all("reset0");
      reset = 0;
      @(posedge clk);
      #1;
      drive(1, 0, 0, 32'h8C22_FFFC, 32'h100);
      cycle();
      drive(0, 0, 0, 0, 0);
      chk("dec.out_valid", 64'(out_valid), 64'd1);
      chk("dec.opcode", 64'(opcode), 64'h23);
      chk("dec.rs", 64'(rs), 64'd1);
      chk("dec.rt", 64'(rt), 64'd2);
      chk("dec.im", 64'(im), 64'hFFFC);
      chk("dec.imm_sext", 64'(imm_sext), 64'hFFFF_FFFC);
      chk("dec.out_pc", 64'(out_pc), 64'h100);
      check_all("dec");
      drive(0, 1, 0, 0, 0);
      cycle();
      check_all("drain1");
      for (int i = 0; i < DEPTH; i++) begin
         drive(1, 0, 0, 32'h1000_0000 + 32'(i), 32'h200 + 32'(4 * i));
         cycle();
      end
      chk("full.count", 64'(count), 64'd4);
      chk("full.in_ready", 64'(in_ready), 64'd0);
      drive(1, 0, 0, 32'hDEAD_BEEF, 32'h300);
      cycle();
      chk("full.fifth", 64'(count), 64'd4);
      check_all("full");
      drive(0, 1, 0, 0, 0);
      cycle();
      chk("full.pop_ready", 64'(in_ready), 64'd1);
      check_all("full.pop");
      drive(1, 1, 1, 32'hBAD0_0001, 32'h400);
      cycle();
      chk("flush.count", 64'(count), 64'd0);
      chk("flush.out_valid", 64'(out_valid), 64'd0);
      drive(0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("flush.stay_empty", 64'(out_valid), 64'd0);
      end
      drive(1, 0, 0, 32'h0123_4567, 32'h500);
      cycle();
      drive(1, 1, 0, 32'h89AB_CDEF, 32'h504);
      cycle();
      chk("pp1.count", 64'(count), 64'd1);
      chk("pp1.head", 64'({opcode, jump_address}), 64'h89AB_CDEF);
      chk("pp1.out_pc", 64'(out_pc), 64'h504);
      check_all("pp1");
      drive(0, 1, 0, 0, 0);
      cycle();
      popped.delete();
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, 0, 32'h0A + 32'(i), 32'h600 + 32'(4 * i));
         cycle();
         chk("stream.count", 64'(count), 64'd1);
         check_all("stream");
      end
      drive(0, 1, 0, 0, 0);
      cycle();
      chk("stream.n", 64'(popped.size()), 64'd10);
      for (int i = 0; i < 10 && i < popped.size(); i++)
         chk("stream.order", 64'(popped[i]), 64'h0A + 64'(i));
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 19) == 0), $urandom, $urandom);
         cycle();
         check_all("rand");
      end
      drive(0, 1, 1, 0, 0);
      cycle();
      drive(1, 0, 0, 32'h1111_1111, 32'h700);
      cycle();
      drive(1, 0, 0, 32'h2222_2222, 32'h704);
      cycle();
      chk("rst.pre_count", 64'(count), 64'd2);
      drive(1, 1, 0, 32'h3333_3333, 32'h708);
      #2 reset = 1;
      #1;
      m_instr.delete();
      m_pc.delete();
      chk("rst.count", 64'(count), 64'd0);
      chk("rst.out_valid", 64'(out_valid), 64'd0);
      chk("rst.in_ready", 64'(in_ready), 64'd1);
      chk("rst.opcode", 64'(opcode), 64'd0);
      chk("rst.imm_sext", 64'(imm_sext), 64'd0);
      check_all("rst");
      #1 reset = 0;
      cycle();
      drive(0, 0, 0, 0, 0);
      check_all("rst.resume");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
